amm_mem_responder: RTL

Avalon-MM burst-capable slave memory model; the responder end of the memory checker's AMM initiator. Accepts burst writes with per-byte byteenable and burst reads, stores data in an internal word array, and returns read data after a fixed latency. Used as the DUT-side memory in checker simulation and in on-chip loopback builds.

---
 rtl/amm_mem_responder.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/amm_mem_responder.sv
// Avalon-MM burst slave memory: byte-enabled burst writes into a word array,
// burst reads returned after a fixed latency. One outstanding read at a time.
module amm_mem_responder #(
  parameter int AMM_DATA_W   = 512,
  parameter int AMM_ADDR_W   = 32,
  parameter int AMM_BURST_W  = 11,
  parameter int MEM_WORDS_W  = 10,
  parameter int READ_LATENCY = 4,
  localparam int DATA_B_W    = AMM_DATA_W / 8,
  localparam int ADDR_B_W    = $clog2(DATA_B_W)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [AMM_ADDR_W-1:0]  amm_address_i,
  input  logic                   amm_read_i,
  input  logic                   amm_write_i,
  input  logic [AMM_DATA_W-1:0]  amm_writedata_i,
  input  logic [DATA_B_W-1:0]    amm_byteenable_i,
  input  logic [AMM_BURST_W-1:0] amm_burstcount_i,
  output logic                   amm_waitrequest_o,
  output logic [AMM_DATA_W-1:0]  amm_readdata_o,
  output logic                   amm_readdatavalid_o,
  output logic                   protocol_err_o,
  output logic [1:0]             fsm_state_o
);

  // Handshake: a request is taken on any rising edge where (read|write) is
  // high and waitrequest is low; readdatavalid qualifies readdata per beat.

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WR_BURST = 2'd1;
  localparam logic [1:0] ST_RD_WAIT  = 2'd2;
  localparam logic [1:0] ST_RD_BURST = 2'd3;

  localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(READ_LATENCY - 1);
  localparam logic [AMM_BURST_W-1:0] BURST_ONE = {{(AMM_BURST_W-1){1'b0}}, 1'b1};
  localparam logic [AMM_BURST_W-1:0] BURST_MAX = {1'b1, {(AMM_BURST_W-1){1'b0}}};

  logic [AMM_DATA_W-1:0]  mem [0:(2**MEM_WORDS_W)-1];

  logic [1:0]             state_q;
  logic                   wait_q;
  logic [MEM_WORDS_W-1:0] beat_idx_q;
  logic [AMM_BURST_W-1:0] left_q;
  logic [LAT_W-1:0]       lat_q;
  logic                   rvalid_q;
  logic [AMM_DATA_W-1:0]  rdata_q;
  logic                   err_q;

  logic                   accepted;
  logic                   burst_bad;
  logic [AMM_BURST_W-1:0] burst_eff;
  logic [MEM_WORDS_W-1:0] cmd_idx;
  logic                   mem_we;
  logic [MEM_WORDS_W-1:0] mem_idx;
  logic                   err_d;
  logic                   addr_unused;

  assign accepted    = (amm_read_i | amm_write_i) & ~wait_q;
  assign burst_bad   = (amm_burstcount_i == '0) || (amm_burstcount_i > BURST_MAX);
  assign burst_eff   = burst_bad ? BURST_ONE : amm_burstcount_i;
  assign cmd_idx     = amm_address_i[ADDR_B_W +: MEM_WORDS_W];
  // Bits outside the word index alias by design.
  assign addr_unused = ^amm_address_i;

  always_comb begin
    mem_we  = 1'b0;
    mem_idx = cmd_idx;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accepted) begin
          mem_we = amm_write_i;
          err_d  = burst_bad | (amm_read_i & amm_write_i);
        end
      end
      ST_WR_BURST: begin
        mem_we  = amm_write_i;
        mem_idx = beat_idx_q;
        err_d   = amm_read_i;
      end
      default: ;
    endcase
  end

  // Storage is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < DATA_B_W; b++) begin
        if (amm_byteenable_i[b]) begin
          mem[mem_idx][b*8 +: 8] <= amm_writedata_i[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      wait_q     <= 1'b1;
      beat_idx_q <= '0;
      left_q     <= '0;
      lat_q      <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q    <= err_d;
      rvalid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          wait_q <= 1'b0;
          if (accepted) begin
            if (amm_write_i) begin
              if (burst_eff != BURST_ONE) begin
                beat_idx_q <= cmd_idx + 1'b1;
                left_q     <= burst_eff - 1'b1;
                state_q    <= ST_WR_BURST;
              end
            end else begin
              beat_idx_q <= cmd_idx;
              left_q     <= burst_eff;
              lat_q      <= LAT_INIT;
              wait_q     <= 1'b1;
              state_q    <= ST_RD_WAIT;
            end
          end
        end
        ST_WR_BURST: begin
          if (amm_write_i) begin
            beat_idx_q <= beat_idx_q + 1'b1;
            left_q     <= left_q - 1'b1;
            if (left_q == BURST_ONE) begin
              state_q <= ST_IDLE;
            end
          end
        end
        ST_RD_WAIT: begin
          if (lat_q == '0) begin
            rvalid_q   <= 1'b1;
            rdata_q    <= mem[beat_idx_q];
            beat_idx_q <= beat_idx_q + 1'b1;
            left_q     <= left_q - 1'b1;
            state_q    <= ST_RD_BURST;
          end else begin
            lat_q <= lat_q - 1'b1;
          end
        end
        ST_RD_BURST: begin
          // Stay here through the last valid beat so waitrequest drops after it.
          if (left_q != '0) begin
            rvalid_q   <= 1'b1;
            rdata_q    <= mem[beat_idx_q];
            beat_idx_q <= beat_idx_q + 1'b1;
            left_q     <= left_q - 1'b1;
          end else begin
            wait_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign amm_waitrequest_o   = wait_q;
  assign amm_readdata_o      = rdata_q;
  assign amm_readdatavalid_o = rvalid_q;
  assign protocol_err_o      = err_q;
  assign fsm_state_o         = state_q;

endmodule
